// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types for the memory-access stage.
// Contents: execute-to-memory input packets, the memory-to-write-back packet,
// named load/store type encodings, the memory-stage FSM state enum, a helper
// that detects misaligned accesses, and a helper that builds the outgoing
// write-back packet.
package rv32_pkg;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b011;
    localparam logic [2:0] LOAD_LHU = 3'b100;

    localparam logic [1:0] STORE_SB = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SW = 2'b10;

    typedef struct packed {
        logic        read_enable;
        logic        write_enable;
        logic [31:0] addr;
        logic [31:0] data;
    } rv32_mem_packet_t;

    typedef struct packed {
        logic [2:0] load_type;
        logic [1:0] store_type;
    } rv32_ex_control_packet_t;

    typedef struct packed {
        logic        valid_opcode;
        logic [4:0]  wb_addr;
        logic [31:0] wb_pc;
        logic [31:0] wb_data;
        logic        wb_enable;
    } rv32_ex2mem_wb_packet_t;

    typedef struct packed {
        logic        valid_opcode;
        logic [4:0]  wb_addr;
        logic [31:0] wb_pc;
        logic [31:0] wb_data;
        logic        wb_enable;
    } rv32_mem2wb_packet_t;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_REQ,
        MEM_RESP,
        MEM_DONE
    } mem_state_t;

    // Byte accesses never fault; halfwords need addr[0]=0; words need addr[1:0]=00.
    // Unknown type encodings are treated as word accesses.
    function automatic logic is_misaligned(input logic       is_load,
                                           input logic [2:0] load_type,
                                           input logic [1:0] store_type,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (is_load) begin
            case (load_type)
                LOAD_LB, LOAD_LBU: mis = 1'b0;
                LOAD_LH, LOAD_LHU: mis = addr_lo[0];
                default:           mis = |addr_lo;
            endcase
        end else begin
            case (store_type)
                STORE_SB: mis = 1'b0;
                STORE_SH: mis = addr_lo[0];
                default:  mis = |addr_lo;
            endcase
        end
        return mis;
    endfunction

    function automatic rv32_mem2wb_packet_t make_wb(input rv32_ex2mem_wb_packet_t p,
                                                    input logic [31:0]           data,
                                                    input logic                  enable);
        rv32_mem2wb_packet_t r;
        r.valid_opcode = p.valid_opcode;
        r.wb_addr      = p.wb_addr;
        r.wb_pc        = p.wb_pc;
        r.wb_data      = data;
        r.wb_enable    = enable;
        return r;
    endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Load data alignment: selects the addressed byte or halfword from the full
// memory word and sign- or zero-extends it according to the load type.
// Ports:
//   addr_lo   in  2  - byte offset of the access within the word
//   load_type in  3  - LB/LH/LW/LBU/LHU encoding
//   rdata     in 32  - full word returned by data memory
//   data      out 32 - aligned, extended load result
module rv32_load_align
    import rv32_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_type,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statements can infer a latch.
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data     = rdata;

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (load_type)
            LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: data = {24'h000000, byte_sel};
            LOAD_LH:  data = {{16{half_sel[15]}}, half_sel};
            LOAD_LHU: data = {16'h0000, half_sel};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage of the in-order RV32IM pipeline. Accepts one execute
// result per handshake, issues at most one data-memory request per
// instruction, aligns load data and emits one write-back packet per
// instruction. Upstream is stalled while a transaction is outstanding.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid / in_ready           - execute handshake
//   mem_packet, ex_control_packet,
//   wb_packet                     - execute outputs captured on transfer
//   dmem_req_*                    - data memory request channel (valid/ready)
//   dmem_rsp_valid/rdata          - data memory load response
//   out_valid, out_wb_packet      - one-cycle write-back pulse and payload
//   misaligned_exc                - flags a misaligned access with out_valid
module mem_access_stage
    import rv32_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  rv32_mem_packet_t        mem_packet,
    input  rv32_ex_control_packet_t ex_control_packet,
    input  rv32_ex2mem_wb_packet_t  wb_packet,
    output logic                    dmem_req_valid,
    input  logic                    dmem_req_ready,
    output logic                    dmem_req_we,
    output logic [31:0]             dmem_req_addr,
    output logic [31:0]             dmem_req_wdata,
    output logic [3:0]              dmem_req_wstrb,
    input  logic                    dmem_rsp_valid,
    input  logic [31:0]             dmem_rsp_rdata,
    output logic                    out_valid,
    output rv32_mem2wb_packet_t     out_wb_packet,
    output logic                    misaligned_exc
);

    mem_state_t state;

    logic        accept;
    logic        in_is_load;
    logic        in_is_mem;
    logic        in_mis;
    logic        in_wb_enable;
    logic [3:0]  in_wstrb;
    logic [31:0] in_wdata;

    // Write-back fields and load alignment info kept while memory is busy.
    // The stored wb_enable already folds in the rd!=0 and misalignment terms.
    rv32_ex2mem_wb_packet_t pend_wb;
    logic                   pend_is_load;
    logic [2:0]             pend_load_type;
    logic [1:0]             pend_addr_lo;
    logic [31:0]            load_data;

    always_comb begin
        accept       = in_valid && in_ready;
        // Both enables set is handled as a load.
        in_is_load   = mem_packet.read_enable;
        in_is_mem    = mem_packet.read_enable || mem_packet.write_enable;
        in_mis       = in_is_mem && is_misaligned(in_is_load, ex_control_packet.load_type,
                                                  ex_control_packet.store_type,
                                                  mem_packet.addr[1:0]);
        in_wb_enable = wb_packet.wb_enable && (wb_packet.wb_addr != 5'd0) && !in_mis;
        in_wstrb     = 4'b0000;
        in_wdata     = 32'h0000_0000;
        if (!in_is_load) begin
            case (ex_control_packet.store_type)
                STORE_SB: begin
                    in_wstrb = 4'b0001 << mem_packet.addr[1:0];
                    in_wdata = {4{mem_packet.data[7:0]}};
                end
                STORE_SH: begin
                    in_wstrb = 4'b0011 << mem_packet.addr[1:0];
                    in_wdata = {2{mem_packet.data[15:0]}};
                end
                default: begin
                    in_wstrb = 4'b1111;
                    in_wdata = mem_packet.data;
                end
            endcase
        end
    end

    rv32_load_align u_load_align (
        .addr_lo   (pend_addr_lo),
        .load_type (pend_load_type),
        .rdata     (dmem_rsp_rdata),
        .data      (load_data)
    );

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= MEM_IDLE;
            in_ready       <= 1'b1;
            dmem_req_valid <= 1'b0;
            dmem_req_we    <= 1'b0;
            dmem_req_addr  <= 32'h0000_0000;
            dmem_req_wdata <= 32'h0000_0000;
            dmem_req_wstrb <= 4'b0000;
            out_valid      <= 1'b0;
            out_wb_packet  <= '0;
            misaligned_exc <= 1'b0;
            pend_wb        <= '0;
            pend_is_load   <= 1'b0;
            pend_load_type <= 3'b000;
            pend_addr_lo   <= 2'b00;
        end else begin
            out_valid      <= 1'b0;
            misaligned_exc <= 1'b0;

            case (state)
                MEM_IDLE, MEM_DONE: begin
                    if (accept) begin
                        pend_wb           <= wb_packet;
                        pend_wb.wb_enable <= in_wb_enable;
                        pend_is_load      <= in_is_load;
                        pend_load_type    <= ex_control_packet.load_type;
                        pend_addr_lo      <= mem_packet.addr[1:0];
                        if (in_is_mem && !in_mis) begin
                            state          <= MEM_REQ;
                            in_ready       <= 1'b0;
                            dmem_req_valid <= 1'b1;
                            dmem_req_we    <= !in_is_load;
                            dmem_req_addr  <= {mem_packet.addr[31:2], 2'b00};
                            dmem_req_wdata <= in_wdata;
                            dmem_req_wstrb <= in_wstrb;
                        end else begin
                            // Non-memory or misaligned: complete without touching memory.
                            state          <= MEM_DONE;
                            in_ready       <= 1'b1;
                            out_valid      <= 1'b1;
                            misaligned_exc <= in_mis;
                            out_wb_packet  <= make_wb(wb_packet, wb_packet.wb_data, in_wb_enable);
                        end
                    end else begin
                        state    <= MEM_IDLE;
                        in_ready <= 1'b1;
                    end
                end

                MEM_REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        dmem_req_we    <= 1'b0;
                        dmem_req_wstrb <= 4'b0000;
                        if (pend_is_load) begin
                            state <= MEM_RESP;
                        end else begin
                            state         <= MEM_DONE;
                            in_ready      <= 1'b1;
                            out_valid     <= 1'b1;
                            out_wb_packet <= make_wb(pend_wb, pend_wb.wb_data, pend_wb.wb_enable);
                        end
                    end
                end

                MEM_RESP: begin
                    if (dmem_rsp_valid) begin
                        state         <= MEM_DONE;
                        in_ready      <= 1'b1;
                        out_valid     <= 1'b1;
                        out_wb_packet <= make_wb(pend_wb, load_data, pend_wb.wb_enable);
                    end
                end

                default: begin
                    state    <= MEM_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// randomized instructions, compared against an access-size based model.
module tb_mem_access_stage;
    import rv32_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    rv32_mem_packet_t        mem_packet;
    rv32_ex_control_packet_t ex_control_packet;
    rv32_ex2mem_wb_packet_t  wb_packet;
    logic                    dmem_req_valid;
    logic                    dmem_req_ready;
    logic                    dmem_req_we;
    logic [31:0]             dmem_req_addr;
    logic [31:0]             dmem_req_wdata;
    logic [3:0]              dmem_req_wstrb;
    logic                    dmem_rsp_valid;
    logic [31:0]             dmem_rsp_rdata;
    logic                    out_valid;
    rv32_mem2wb_packet_t     out_wb_packet;
    logic                    misaligned_exc;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .mem_packet        (mem_packet),
        .ex_control_packet (ex_control_packet),
        .wb_packet         (wb_packet),
        .dmem_req_valid    (dmem_req_valid),
        .dmem_req_ready    (dmem_req_ready),
        .dmem_req_we       (dmem_req_we),
        .dmem_req_addr     (dmem_req_addr),
        .dmem_req_wdata    (dmem_req_wdata),
        .dmem_req_wstrb    (dmem_req_wstrb),
        .dmem_rsp_valid    (dmem_rsp_valid),
        .dmem_rsp_rdata    (dmem_rsp_rdata),
        .out_valid         (out_valid),
        .out_wb_packet     (out_wb_packet),
        .misaligned_exc    (misaligned_exc)
    );

    typedef struct packed {
        logic                is_mem;
        logic                mis;
        logic                we;
        logic [31:0]         addr;
        logic [31:0]         wdata;
        logic [3:0]          wstrb;
        rv32_mem2wb_packet_t wb;
    } exp_t;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: access size and byte offset drive everything.
    function automatic exp_t model(input rv32_mem_packet_t        m,
                                   input rv32_ex_control_packet_t c,
                                   input rv32_ex2mem_wb_packet_t  w,
                                   input logic [31:0]             rdata);
        exp_t        e;
        int          off;
        int          size;
        logic        ld;
        logic        st;
        logic        sgn;
        logic [31:0] val;
        off = int'(m.addr[1:0]);
        ld  = m.read_enable;
        st  = m.write_enable && !m.read_enable;
        if (ld) size = (c.load_type == LOAD_LB || c.load_type == LOAD_LBU) ? 1 :
                       (c.load_type == LOAD_LH || c.load_type == LOAD_LHU) ? 2 : 4;
        else    size = (c.store_type == STORE_SB) ? 1 : (c.store_type == STORE_SH) ? 2 : 4;
        sgn      = (c.load_type == LOAD_LB) || (c.load_type == LOAD_LH);
        e.is_mem = ld || st;
        e.mis    = e.is_mem && ((off % size) != 0);
        e.we     = st;
        e.addr   = m.addr & 32'hFFFF_FFFC;
        e.wstrb  = st ? 4'(((1 << size) - 1) << off) : 4'b0000;
        if (!st)            e.wdata = 32'h0;
        else if (size == 1) e.wdata = m.data[7:0] * 32'h0101_0101;
        else if (size == 2) e.wdata = m.data[15:0] * 32'h0001_0001;
        else                e.wdata = m.data;
        val = rdata >> (8 * off);
        if (size == 1) begin
            val = val & 32'h0000_00FF;
            if (sgn && val[7]) val = val | 32'hFFFF_FF00;
        end else if (size == 2) begin
            val = val & 32'h0000_FFFF;
            if (sgn && val[15]) val = val | 32'hFFFF_0000;
        end
        e.wb.valid_opcode = w.valid_opcode;
        e.wb.wb_addr      = w.wb_addr;
        e.wb.wb_pc        = w.wb_pc;
        e.wb.wb_data      = (ld && !e.mis) ? val : w.wb_data;
        e.wb.wb_enable    = w.wb_enable && (w.wb_addr != 5'd0) && !e.mis;
        return e;
    endfunction

    // Drives one instruction through the stage; returns in the cycle where
    // out_valid is expected, so the next call transfers in the DONE cycle.
    task automatic run_instr(input rv32_mem_packet_t        m,
                             input rv32_ex_control_packet_t c,
                             input rv32_ex2mem_wb_packet_t  w,
                             input logic [31:0]             rdata,
                             input int                      ready_delay,
                             input int                      rsp_delay);
        exp_t e;
        e = model(m, c, w, rdata);
        check("in_ready_before", in_ready, 1'b1);
        mem_packet        = m;
        ex_control_packet = c;
        wb_packet         = w;
        in_valid          = 1'b1;
        tick();
        in_valid = 1'b0;
        if (!e.is_mem || e.mis) begin
            check("out_valid", out_valid, 1'b1);
            check("wb_packet", out_wb_packet, e.wb);
            check("misaligned_exc", misaligned_exc, e.mis);
            check("no_req", dmem_req_valid, 1'b0);
        end else begin
            for (int i = 0; i <= ready_delay; i++) begin
                check("req_valid", dmem_req_valid, 1'b1);
                check("req_fields", {dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb},
                      {e.we, e.addr, e.wdata, e.wstrb});
                check("in_ready_busy", in_ready, 1'b0);
                check("no_out_req", out_valid, 1'b0);
                dmem_req_ready = (i == ready_delay);
                dmem_rsp_valid = 1'($urandom_range(0, 1));
                dmem_rsp_rdata = $urandom;
                tick();
            end
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b0;
            if (!e.we) begin
                for (int i = 0; i < rsp_delay; i++) begin
                    check("no_out_resp", out_valid, 1'b0);
                    check("req_dropped", dmem_req_valid, 1'b0);
                    check("in_ready_resp", in_ready, 1'b0);
                    tick();
                end
                dmem_rsp_valid = 1'b1;
                dmem_rsp_rdata = rdata;
                tick();
                dmem_rsp_valid = 1'b0;
                dmem_rsp_rdata = $urandom;
            end
            check("out_valid", out_valid, 1'b1);
            check("wb_packet", out_wb_packet, e.wb);
            check("misaligned_exc", misaligned_exc, 1'b0);
        end
    endtask

    rv32_mem_packet_t        m;
    rv32_ex_control_packet_t c;
    rv32_ex2mem_wb_packet_t  w;
    int                      kind;

    initial begin
        rst               = 1'b1;
        in_valid          = 1'b0;
        mem_packet        = '0;
        ex_control_packet = '0;
        wb_packet         = '0;
        dmem_req_ready    = 1'b0;
        dmem_rsp_valid    = 1'b0;
        dmem_rsp_rdata    = 32'h0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_req", {dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb}, 70'h0);
        check("rst_out", {out_valid, misaligned_exc, out_wb_packet}, 73'h0);
        rst = 1'b0;

        // ADD, rd=3 then rd=0; back-to-back one per cycle.
        m = '0; c = '0;
        w = '{valid_opcode: 1'b1, wb_addr: 5'd3, wb_pc: 32'h0000_1000, wb_data: 32'h5, wb_enable: 1'b1};
        run_instr(m, c, w, 32'h0, 0, 0);
        check("add_wb_data", out_wb_packet.wb_data, 32'h5);
        check("add_wb_enable", out_wb_packet.wb_enable, 1'b1);
        w.wb_addr = 5'd0;
        run_instr(m, c, w, 32'h0, 0, 0);
        check("add_rd0_wb_enable", out_wb_packet.wb_enable, 1'b0);

        // LB / LBU at 0x103.
        m = '{read_enable: 1'b1, write_enable: 1'b0, addr: 32'h103, data: 32'h0};
        c = '{load_type: LOAD_LB, store_type: STORE_SB};
        w = '{valid_opcode: 1'b1, wb_addr: 5'd7, wb_pc: 32'h0000_1008, wb_data: 32'h0, wb_enable: 1'b1};
        run_instr(m, c, w, 32'h80FF_1234, 0, 0);
        check("lb_data", out_wb_packet.wb_data, 32'hFFFF_FF80);
        c.load_type = LOAD_LBU;
        run_instr(m, c, w, 32'h80FF_1234, 0, 2);
        check("lbu_data", out_wb_packet.wb_data, 32'h0000_0080);

        // SH at 0x202.
        m = '{read_enable: 1'b0, write_enable: 1'b1, addr: 32'h202, data: 32'h0000_BEEF};
        c = '{load_type: LOAD_LW, store_type: STORE_SH};
        w = '{valid_opcode: 1'b1, wb_addr: 5'd0, wb_pc: 32'h0000_1010, wb_data: 32'h0, wb_enable: 1'b0};
        run_instr(m, c, w, 32'h0, 0, 0);
        check("sh_wb_enable", out_wb_packet.wb_enable, 1'b0);

        // Misaligned LW at 0x101.
        m = '{read_enable: 1'b1, write_enable: 1'b0, addr: 32'h101, data: 32'h0};
        c = '{load_type: LOAD_LW, store_type: STORE_SB};
        w = '{valid_opcode: 1'b1, wb_addr: 5'd9, wb_pc: 32'h0000_1014, wb_data: 32'h1234, wb_enable: 1'b1};
        run_instr(m, c, w, 32'h0, 0, 0);
        check("lw_mis_exc", misaligned_exc, 1'b1);

        // SW with three cycles of backpressure.
        m = '{read_enable: 1'b0, write_enable: 1'b1, addr: 32'h400, data: 32'hCAFE_F00D};
        c = '{load_type: LOAD_LW, store_type: STORE_SW};
        w = '{valid_opcode: 1'b1, wb_addr: 5'd0, wb_pc: 32'h0000_1018, wb_data: 32'h0, wb_enable: 1'b0};
        run_instr(m, c, w, 32'h0, 3, 0);

        // Both enables: treated as a load.
        m = '{read_enable: 1'b1, write_enable: 1'b1, addr: 32'h502, data: 32'hFFFF_FFFF};
        c = '{load_type: LOAD_LH, store_type: STORE_SW};
        w = '{valid_opcode: 1'b1, wb_addr: 5'd4, wb_pc: 32'h0000_101C, wb_data: 32'h0, wb_enable: 1'b1};
        run_instr(m, c, w, 32'h8001_7FFF, 1, 1);
        check("both_en_lh", out_wb_packet.wb_data, 32'hFFFF_8001);

        // Reset while waiting for a load response; the late response is ignored.
        m = '{read_enable: 1'b1, write_enable: 1'b0, addr: 32'h300, data: 32'h0};
        c = '{load_type: LOAD_LW, store_type: STORE_SB};
        mem_packet = m; ex_control_packet = c; wb_packet = w;
        in_valid = 1'b1;
        tick();
        in_valid       = 1'b0;
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        check("resp_in_ready", in_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_resp_in_ready", in_ready, 1'b1);
        check("rst_resp_req", dmem_req_valid, 1'b0);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_rsp_valid = 1'b0;
        check("late_rsp_no_out", out_valid, 1'b0);
        check("late_rsp_in_ready", in_ready, 1'b1);
        tick();
        check("late_rsp_no_out2", out_valid, 1'b0);

        // Randomized instruction stream.
        for (int n = 0; n < 200; n++) begin
            kind             = $urandom_range(0, 3);
            m.read_enable    = (kind == 1) || (kind == 3);
            m.write_enable   = (kind == 2) || (kind == 3);
            m.addr           = $urandom;
            m.data           = $urandom;
            c.load_type      = 3'($urandom_range(0, 4));
            c.store_type     = 2'($urandom_range(0, 2));
            w.valid_opcode   = 1'($urandom_range(0, 1));
            w.wb_addr        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            w.wb_pc          = $urandom;
            w.wb_data        = $urandom;
            w.wb_enable      = 1'($urandom_range(0, 1));
            run_instr(m, c, w, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                tick();
                check("idle_no_out", out_valid, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the in-order single-issue RV32IM pipeline, directly downstream of `execute_stage`. Captures one execute result per handshake, performs loads and stores against a single-port data memory over a valid/ready request channel with a separate response channel, aligns and extends load data, and presents one write-back packet per instruction to the write-back stage. It stalls the upstream stage while a memory transaction is outstanding.

## Interface
No parameters. Data width is fixed at 32.
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `in_valid` in 1 — execute outputs hold a valid instruction
- `in_ready` out 1 — stage accepts this cycle; transfer when `in_valid && in_ready`
- `mem_packet` in `rv32_mem_packet_t` — `read_enable`, `write_enable`, `addr`, `data` (store data zero-extended in low bits)
- `ex_control_packet` in `rv32_ex_control_packet_t` — `load_type` (000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU), `store_type` (00 SB, 01 SH, 10 SW)
- `wb_packet` in `rv32_ex2mem_wb_packet_t` — execute write-back fields
- `dmem_req_valid` out 1; `dmem_req_ready` in 1
- `dmem_req_we` out 1 — 1 store, 0 load
- `dmem_req_addr` out 32 — word address, bits [1:0] = 00
- `dmem_req_wdata` out 32 — store data shifted to byte lane
- `dmem_req_wstrb` out 4 — byte enables; 0000 for loads
- `dmem_rsp_valid` in 1; `dmem_rsp_rdata` in 32 — full load word, one response per load request
- `out_valid` out 1 — one-cycle pulse per completed instruction
- `out_wb_packet` out `rv32_mem2wb_packet_t` — `valid_opcode`, `wb_addr`, `wb_pc`, `wb_data`, `wb_enable`
- `misaligned_exc` out 1 — pulses with `out_valid` for a misaligned access

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Input fields registered on accept.
- IDLE: `in_ready`=1; on transfer: non-memory or misaligned → DONE; load/store → REQ.
- REQ: `dmem_req_valid`=1, all request fields held stable until `dmem_req_ready`. On acceptance: store → DONE; load → RESP.
- RESP: waits for `dmem_rsp_valid`, captures aligned/extended data, → DONE.
- DONE: `out_valid`=1 for one cycle, `in_ready`=1; a new transfer this cycle goes to REQ/DONE as from IDLE, otherwise → IDLE. The write-back stage never stalls.
- `in_ready`=0 in REQ and RESP.
- Store lanes: SB `wstrb`=0001<<addr[1:0], `wdata`=byte replicated ×4; SH `wstrb`=0011<<addr[1:0], halfword replicated ×2; SW `wstrb`=1111.
- Load extraction: byte/halfword selected by addr[1:0]; LB/LH sign-extended, LBU/LHU zero-extended.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠00. No memory request issued; `wb_enable`=0; `misaligned_exc`=1 with `out_valid`.
- `wb_data` = load data for loads, otherwise execute `wb_data` passed through. `wb_enable` = execute `wb_enable` && `wb_addr`≠0 && not misaligned.
- `read_enable` and `write_enable` both set: treated as load.
- `dmem_rsp_valid` outside RESP is ignored.

## Timing
- Reset: state IDLE; `in_ready`=1; `dmem_req_valid`, `dmem_req_we`, `out_valid`, `misaligned_exc`=0; `dmem_req_addr`, `wdata`, `wstrb`=0; `out_wb_packet` all zero.
- Non-memory or misaligned instruction: accept at edge N, `out_valid` in cycle N+1.
- Back-to-back non-memory instructions sustain one per cycle.
- Store: accept at N, request in N+1, `out_valid` one cycle after the request is accepted (N+2 with zero wait).
- Load: accept at N, request in N+1, response earliest N+2, `out_valid` in N+3.
- Reset in any state returns to IDLE next edge, discards any outstanding transaction, and ignores a late response.

## Structure
- Package `rv32_pkg` gains `rv32_mem2wb_packet_t`, named load/store type constants, and the FSM state enum.
- One sub-module: `rv32_load_align`, a combinational byte/halfword select plus sign/zero extension (addr[1:0], load_type, rdata → 32-bit data).

## Test plan
- ADD result 0x0000_0005, rd=3 → `out_valid` next cycle, `wb_data`=5, `wb_enable`=1; rd=0 → `wb_enable`=0.
- LB addr 0x103, rsp rdata 0x80FF_1234 → request addr 0x100, `wb_data`=0xFFFF_FF80; LBU → 0x0000_0080.
- SH addr 0x202, data 0xBEEF → addr 0x200, `wstrb`=1100, `wdata`=0xBEEF_BEEF, `wb_enable`=0.
- LW addr 0x101 → no `dmem_req_valid`, `misaligned_exc`=1 with `out_valid`, `wb_enable`=0.
- Hold `dmem_req_ready`=0 for 3 cycles on SW → request fields stable, `in_ready`=0 throughout, completes on the 4th cycle.
- Assert `rst` in RESP, then deliver `dmem_rsp_valid` → no `out_valid`, state IDLE, `in_ready`=1.
